// File: rtl/demux_stripe_1x4_pkg.sv
// Shared constants and state encoding for the 1-to-4 byte striping demux.
package demux_stripe_1x4_pkg;

    localparam int         NUM_LANES        = 4;
    localparam int         LANE_IDX_W       = 2;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hF7;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/demux_stripe_1x4.sv
// Stripes a serial byte stream across four lanes, emitting one registered word
// per four accepted bytes or per end-of-packet flush, with padded lanes flagged.
module demux_stripe_1x4 #(
    parameter logic [7:0] PAD_BYTE  = demux_stripe_1x4_pkg::PAD_BYTE_DEFAULT,
    parameter int         NUM_LANES = demux_stripe_1x4_pkg::NUM_LANES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_end,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       out_valid,
    output logic [3:0] out_pad_mask
);
    import demux_stripe_1x4_pkg::*;

    state_t                  state, state_d;
    logic [LANE_IDX_W-1:0]   idx, idx_d;
    logic [7:0]              hold_p0 [NUM_LANES];

    logic                    emit;
    logic [7:0]              word_d  [NUM_LANES];
    logic [NUM_LANES-1:0]    mask_d;

    logic [7:0]              word_p1 [NUM_LANES];
    logic [NUM_LANES-1:0]    mask_p1;
    logic                    vld_p1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Next-state logic: any emitted word returns the lane index to zero
    always_comb begin
        state_d = state;
        idx_d   = idx;
        if (emit) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (in_valid) begin
            state_d = FILL;
            idx_d   = idx + 1'b1;
        end
    end

    // Output decode: builds the candidate word from held lanes, the incoming
    // byte at idx (if any), and pad bytes everywhere above that point.
    always_comb begin
        emit = (in_valid && (in_end || idx == LANE_IDX_W'(NUM_LANES - 1))) ||
               (!in_valid && in_end && state == FILL);
        for (int l = 0; l < NUM_LANES; l++) begin
            word_d[l] = PAD_BYTE;
            mask_d[l] = 1'b1;
            if (l < int'(idx)) begin
                word_d[l] = hold_p0[l];
                mask_d[l] = 1'b0;
            end else if (l == int'(idx) && in_valid) begin
                word_d[l] = in_data;
                mask_d[l] = 1'b0;
            end
        end
    end

    // Stage p0: holding registers capture each accepted byte at its lane
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                hold_p0[l] <= '0;
            end
        end else if (in_valid && !emit) begin
            hold_p0[idx] <= in_data;
        end
    end

    // Stage p1: output word, pad mask and one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            mask_p1 <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                word_p1[l] <= '0;
            end
        end else begin
            vld_p1 <= emit;
            if (emit) begin
                mask_p1 <= mask_d;
                for (int l = 0; l < NUM_LANES; l++) begin
                    word_p1[l] <= word_d[l];
                end
            end
        end
    end

    assign out0         = word_p1[0];
    assign out1         = word_p1[1];
    assign out2         = word_p1[2];
    assign out3         = word_p1[3];
    assign out_valid    = vld_p1;
    assign out_pad_mask = mask_p1;

endmodule

// File: tb/tb_demux_stripe_1x4.sv
// Directed bench for demux_stripe_1x4: full words, flushes, reset discard and gaps.
module tb_demux_stripe_1x4;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_end;
    logic [7:0] out0, out1, out2, out3;
    logic       out_valid;
    logic [3:0] out_pad_mask;

    int n_chk;
    int n_fail;

    demux_stripe_1x4 dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_end       (in_end),
        .out0         (out0),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3),
        .out_valid    (out_valid),
        .out_pad_mask (out_pad_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word();
        return {out0, out1, out2, out3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic e, input logic [7:0] d);
        in_valid = v;
        in_end   = e;
        in_data  = d;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        put(1'b1, 1'b1, 8'h99);
        put(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid);
        end
        n_chk++;
        if (word() !== 32'h0) begin
            n_fail++; $display("FAIL reset_word got %h want 00000000", word());
        end
        n_chk++;
        if (out_pad_mask !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mask got %b want 0000", out_pad_mask);
        end
        // A lone in_end in IDLE must produce nothing
        put(1'b0, 1'b1, 8'h00);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_end_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_full_words();
        logic [31:0] exp_w;
        for (int i = 1; i <= 8; i++) begin
            put(1'b1, 1'b0, 8'(i));
            n_chk++;
            if (out_valid !== ((i % 4) == 0)) begin
                n_fail++; $display("FAIL full_valid_%0d got %0b want %0b", i, out_valid, (i % 4) == 0);
            end
            if ((i % 4) == 0) begin
                exp_w = (i == 4) ? 32'h01020304 : 32'h05060708;
                n_chk++;
                if (word() !== exp_w) begin
                    n_fail++; $display("FAIL full_word_%0d got %h want %h", i, word(), exp_w);
                end
                n_chk++;
                if (out_pad_mask !== 4'b0000) begin
                    n_fail++; $display("FAIL full_mask_%0d got %b want 0000", i, out_pad_mask);
                end
            end
        end
        put(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (out_valid !== 1'b0 || word() !== 32'h05060708) begin
            n_fail++; $display("FAIL full_hold got v=%0b %h want v=0 05060708", out_valid, word());
        end
    endtask

    task automatic test_short_flush();
        put(1'b1, 1'b0, 8'hAA);
        put(1'b1, 1'b0, 8'hBB);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_early_valid got %0b want 0", out_valid);
        end
        put(1'b1, 1'b1, 8'hCC);
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'hAABBCCF7 || out_pad_mask !== 4'b1000) begin
            n_fail++; $display("FAIL short_word got v=%0b %h m=%b want v=1 AABBCCF7 m=1000",
                               out_valid, word(), out_pad_mask);
        end
        put(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_single_pulse got %0b want 0", out_valid);
        end
        // Single byte with in_end from IDLE
        put(1'b1, 1'b1, 8'h66);
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'h66F7F7F7 || out_pad_mask !== 4'b1110) begin
            n_fail++; $display("FAIL single_end got v=%0b %h m=%b want v=1 66F7F7F7 m=1110",
                               out_valid, word(), out_pad_mask);
        end
    endtask

    task automatic test_lone_end();
        put(1'b1, 1'b0, 8'h11);
        put(1'b0, 1'b0, 8'h00);
        put(1'b0, 1'b1, 8'h00);
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'h11F7F7F7 || out_pad_mask !== 4'b1110) begin
            n_fail++; $display("FAIL lone_end got v=%0b %h m=%b want v=1 11F7F7F7 m=1110",
                               out_valid, word(), out_pad_mask);
        end
        put(1'b0, 1'b1, 8'h00);
        n_chk++;
        if (out_valid !== 1'b0 || word() !== 32'h11F7F7F7) begin
            n_fail++; $display("FAIL lone_end_second got v=%0b %h want v=0 11F7F7F7", out_valid, word());
        end
        // Flush with three held bytes pads only lane 3
        put(1'b1, 1'b0, 8'h71);
        put(1'b1, 1'b0, 8'h72);
        put(1'b1, 1'b0, 8'h73);
        put(1'b0, 1'b1, 8'h00);
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'h717273F7 || out_pad_mask !== 4'b1000) begin
            n_fail++; $display("FAIL flush3 got v=%0b %h m=%b want v=1 717273F7 m=1000",
                               out_valid, word(), out_pad_mask);
        end
        put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_discard();
        int pulses;
        put(1'b1, 1'b0, 8'h21);
        put(1'b1, 1'b0, 8'h22);
        reset = 1'b1;
        put(1'b1, 1'b1, 8'h23);
        reset = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || word() !== 32'h0 || out_pad_mask !== 4'b0000) begin
            n_fail++; $display("FAIL rst_discard got v=%0b %h m=%b want v=0 00000000 m=0000",
                               out_valid, word(), out_pad_mask);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1'b0, 8'(8'h31 + i));
            if (out_valid === 1'b1) pulses++;
        end
        put(1'b0, 1'b0, 8'h00);
        if (out_valid === 1'b1) pulses++;
        n_chk++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL rst_pulses got %0d want 1", pulses);
        end
        n_chk++;
        if (word() !== 32'h31323334 || out_pad_mask !== 4'b0000) begin
            n_fail++; $display("FAIL rst_word got %h m=%b want 31323334 m=0000", word(), out_pad_mask);
        end
    endtask

    task automatic test_back_to_back();
        put(1'b1, 1'b0, 8'h41);
        put(1'b1, 1'b0, 8'h42);
        put(1'b1, 1'b0, 8'h43);
        put(1'b1, 1'b1, 8'h44);
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'h41424344 || out_pad_mask !== 4'b0000) begin
            n_fail++; $display("FAIL end4_word got v=%0b %h m=%b want v=1 41424344 m=0000",
                               out_valid, word(), out_pad_mask);
        end
        put(1'b1, 1'b0, 8'h45);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL end4_no_extra got %0b want 0", out_valid);
        end
        put(1'b1, 1'b0, 8'h46);
        put(1'b1, 1'b0, 8'h47);
        put(1'b1, 1'b0, 8'h48);
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'h45464748) begin
            n_fail++; $display("FAIL b2b_word got v=%0b %h want v=1 45464748", out_valid, word());
        end
    endtask

    task automatic test_gapped();
        int early;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1'b0, 8'(8'h51 + i));
            if (i < 3) begin
                if (out_valid !== 1'b0 || word() !== 32'h45464748) early++;
                put(1'b0, 1'b0, 8'hEE);
                if (out_valid !== 1'b0 || word() !== 32'h45464748) early++;
            end
        end
        n_chk++;
        if (early != 0) begin
            n_fail++; $display("FAIL gap_hold_before got %0d bad cycles want 0", early);
        end
        n_chk++;
        if (out_valid !== 1'b1 || word() !== 32'h51525354 || out_pad_mask !== 4'b0000) begin
            n_fail++; $display("FAIL gap_word got v=%0b %h m=%b want v=1 51525354 m=0000",
                               out_valid, word(), out_pad_mask);
        end
        put(1'b0, 1'b0, 8'h00);
        put(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (out_valid !== 1'b0 || word() !== 32'h51525354) begin
            n_fail++; $display("FAIL gap_hold_after got v=%0b %h want v=0 51525354", out_valid, word());
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_end   = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_full_words();
        test_short_flush();
        test_lone_end();
        test_reset_discard();
        test_back_to_back();
        test_gapped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
